// File: rtl/lut_ram_ctrl_pkg.sv
// Shared types for the lut_ram command controller: data word, command opcodes
// and controller FSM states.
package lut_ram_ctrl_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    OP_FILL  = 2'd0,
    OP_COPY  = 2'd1,
    OP_CHECK = 2'd2,
    OP_RSVD  = 2'd3
  } lut_ram_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } lut_ram_ctrl_state_t;

  // Reserved opcodes complete immediately without touching memory.
  function automatic logic op_is_valid(input lut_ram_op_t op);
    return op != OP_RSVD;
  endfunction

endpackage

// File: rtl/lut_ram_ctrl_if.sv
// Command handshake, status and lut_ram port bundle between a host and the
// lut_ram_ctrl initiator.
interface lut_ram_ctrl_if #(
  parameter int ADDR_WIDTH = 8
) ();

  logic                          cmd_valid;
  logic                          cmd_ready;
  lut_ram_ctrl_pkg::lut_ram_op_t cmd_op;
  logic [ADDR_WIDTH-1:0]         cmd_src;
  logic [ADDR_WIDTH-1:0]         cmd_dst;
  logic [ADDR_WIDTH:0]           cmd_len;
  lut_ram_ctrl_pkg::word_t       cmd_data;

  logic                          busy;
  logic                          done;
  logic [ADDR_WIDTH:0]           mismatch_count;

  logic                          mem_wr_en;
  logic [ADDR_WIDTH-1:0]         mem_wr_addr;
  lut_ram_ctrl_pkg::word_t       mem_wr_data;
  logic [ADDR_WIDTH-1:0]         mem_rd_addr;
  lut_ram_ctrl_pkg::word_t       mem_rd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_data, mem_rd_data,
    input  cmd_ready, busy, done, mismatch_count,
    input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_data, mem_rd_data,
    output cmd_ready, busy, done, mismatch_count,
    output mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr
  );

endinterface

// File: rtl/lut_ram_addr_gen.sv
// Element counter for lut_ram_ctrl: produces the per-element offset (ascending
// or descending), the wrapped source/destination addresses and a last flag.
module lut_ram_addr_gen #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  step_i,
  input  logic                  desc_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic [ADDR_WIDTH-1:0] src_i,
  input  logic [ADDR_WIDTH-1:0] dst_i,
  output logic [ADDR_WIDTH-1:0] src_addr_o,
  output logic [ADDR_WIDTH-1:0] dst_addr_o,
  output logic                  last_o
);

  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [ADDR_WIDTH:0]   last_idx;
  logic [ADDR_WIDTH-1:0] offs;

  assign last_idx = len_i - ONE;

  always_comb begin
    idx_d = idx_q;
    if (clear_i) begin
      idx_d = '0;
    end else if (step_i) begin
      idx_d = idx_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // Offsets and sums are truncated to ADDR_WIDTH so addresses wrap modulo DEPTH.
  assign offs       = desc_i ? (last_idx[ADDR_WIDTH-1:0] - idx_q[ADDR_WIDTH-1:0])
                             : idx_q[ADDR_WIDTH-1:0];
  assign src_addr_o = src_i + offs;
  assign dst_addr_o = dst_i + offs;
  assign last_o     = (idx_q == last_idx);

endmodule

// File: rtl/lut_ram_ctrl.sv
// Command-driven initiator for lut_ram: runs one FILL, COPY or CHECK command,
// one element per clock, and reports completion and CHECK mismatches.
module lut_ram_ctrl
  import lut_ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  lut_ram_ctrl_if.slave bus
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  lut_ram_ctrl_state_t   state_q, state_d;
  lut_ram_op_t           op_q;
  logic [ADDR_WIDTH-1:0] src_q, dst_q;
  logic [LW-1:0]         len_q;
  word_t                 data_q;
  logic [LW-1:0]         mism_q, mism_d;

  logic                  accept;
  logic                  running;
  logic                  last;
  logic                  desc;
  logic [ADDR_WIDTH-1:0] src_addr, dst_addr;

  assign accept  = (state_q == ST_IDLE) && bus.cmd_valid;
  assign running = (state_q == ST_RUN);
  // Only COPY walks backwards, so an overlapping move never reads a clobbered element.
  assign desc    = (op_q == OP_COPY) && (dst_q > src_q);

  lut_ram_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (accept),
    .step_i    (running),
    .desc_i    (desc),
    .len_i     (len_q),
    .src_i     (src_q),
    .dst_i     (dst_q),
    .src_addr_o(src_addr),
    .dst_addr_o(dst_addr),
    .last_o    (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_FILL;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      data_q <= '0;
      mism_q <= '0;
    end else begin
      mism_q <= mism_d;
      if (accept) begin
        op_q   <= bus.cmd_op;
        src_q  <= bus.cmd_src;
        dst_q  <= bus.cmd_dst;
        len_q  <= bus.cmd_len;
        data_q <= bus.cmd_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (bus.cmd_len == '0 || !op_is_valid(bus.cmd_op)) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN:  if (last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mism_d = mism_q;
    if (accept) begin
      mism_d = '0;
    end else if (running && op_q == OP_CHECK && bus.mem_rd_data != data_q) begin
      mism_d = mism_q + ONE;
    end
  end

  // Memory port decode depends only on registered state, never on cmd_* inputs.
  always_comb begin
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_addr = '0;
    bus.mem_wr_data = '0;
    bus.mem_rd_addr = '0;
    if (running) begin
      case (op_q)
        OP_FILL: begin
          bus.mem_wr_en   = 1'b1;
          bus.mem_wr_addr = dst_addr;
          bus.mem_wr_data = data_q;
        end
        OP_COPY: begin
          bus.mem_rd_addr = src_addr;
          bus.mem_wr_en   = 1'b1;
          bus.mem_wr_addr = dst_addr;
          bus.mem_wr_data = bus.mem_rd_data;
        end
        OP_CHECK: begin
          bus.mem_rd_addr = src_addr;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.cmd_ready      = (state_q == ST_IDLE);
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.done           = (state_q == ST_DONE);
  assign bus.mismatch_count = mism_q;

endmodule

// File: tb/tb_lut_ram_ctrl.sv
// Self-checking bench for lut_ram_ctrl: behavioural lut_ram, transaction-level
// reference model with per-cycle expected outputs, directed and random commands.
module tb_lut_ram_ctrl;
  import lut_ram_ctrl_pkg::*;

  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lut_ram_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  lut_ram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Behavioural lut_ram: combinational read, write on posedge.
  word_t mem [DEPTH];
  bit    mem_init_done = 1'b0;

  function automatic word_t init_word(input int a);
    return 32'hDEAD_0000 | 32'(a);
  endfunction

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= init_word(a);
      mem_init_done <= 1'b1;
    end else if (bus.mem_wr_en) begin
      mem[bus.mem_wr_addr] <= bus.mem_wr_data;
    end
  end
  assign bus.mem_rd_data = mem[bus.mem_rd_addr];

  // Reference model state
  word_t ref_mem [DEPTH];

  typedef struct packed {
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    word_t         wr_data;
    logic [AW-1:0] rd_addr;
    logic          done;
    logic          busy;
    logic          chk_mism;
    logic [AW:0]   mism;
  } exp_t;

  exp_t        expq[$];
  exp_t        cmp_e;
  logic [AW:0] held_mism = '0;
  bit          chk_en = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, want, $time);
    end
  endtask

  // Build the cycle-by-cycle expectation of one accepted command and update ref_mem.
  task automatic push_expect(input int op, input int src, input int dst, input int len, input word_t data);
    word_t snap [DEPTH];
    exp_t  e;
    int    mm;
    int    k;
    snap = ref_mem;
    mm   = 0;
    if (op != 3) begin
      for (int j = 0; j < len; j++) begin
        e      = '0;
        e.busy = 1'b1;
        case (op)
          0: begin
            e.wr_en   = 1'b1;
            e.wr_addr = AW'(dst + j);
            e.wr_data = data;
            ref_mem[AW'(dst + j)] = data;
          end
          1: begin
            k         = (dst > src) ? (len - 1 - j) : j;
            e.rd_addr = AW'(src + k);
            e.wr_en   = 1'b1;
            e.wr_addr = AW'(dst + k);
            e.wr_data = snap[AW'(src + k)];
          end
          default: begin
            e.rd_addr = AW'(src + j);
            if (snap[AW'(src + j)] != data) mm++;
          end
        endcase
        expq.push_back(e);
      end
      if (op == 1) begin
        for (int j = 0; j < len; j++) ref_mem[AW'(dst + j)] = snap[AW'(src + j)];
      end
    end
    e          = '0;
    e.busy     = 1'b1;
    e.done     = 1'b1;
    e.chk_mism = 1'b1;
    e.mism     = (AW + 1)'(mm);
    expq.push_back(e);
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      if (expq.size() > 0) begin
        cmp_e = expq.pop_front();
      end else begin
        cmp_e          = '0;
        cmp_e.chk_mism = 1'b1;
        cmp_e.mism     = held_mism;
      end
      if (cmp_e.done) held_mism = cmp_e.mism;
      chk("mem_wr_en",   bus.mem_wr_en,   cmp_e.wr_en);
      chk("mem_wr_addr", bus.mem_wr_addr, cmp_e.wr_addr);
      chk("mem_wr_data", bus.mem_wr_data, cmp_e.wr_data);
      chk("mem_rd_addr", bus.mem_rd_addr, cmp_e.rd_addr);
      chk("done",        bus.done,        cmp_e.done);
      chk("busy",        bus.busy,        cmp_e.busy);
      chk("cmd_ready",   bus.cmd_ready,   !cmp_e.busy);
      if (cmp_e.chk_mism) chk("mismatch_count", bus.mismatch_count, cmp_e.mism);
    end
  end

  task automatic do_cmd(input int op, input int src, input int dst, input int len,
                        input word_t data, input bit noise, output int lat);
    int guard;
    guard = 0;
    while (!bus.cmd_ready && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.cmd_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: got=0 want=1");
      lat = -1;
      return;
    end
    bus.cmd_op    = lut_ram_op_t'(op[1:0]);
    bus.cmd_src   = src[AW-1:0];
    bus.cmd_dst   = dst[AW-1:0];
    bus.cmd_len   = len[AW:0];
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    push_expect(op, src, dst, len, data);
    bus.cmd_valid = noise;
    if (noise) begin
      bus.cmd_op   = lut_ram_op_t'(2'($urandom_range(0, 2)));
      bus.cmd_src  = AW'($urandom_range(0, DEPTH - 1));
      bus.cmd_dst  = AW'($urandom_range(0, DEPTH - 1));
      bus.cmd_len  = (AW + 1)'($urandom_range(1, 20));
      bus.cmd_data = $urandom;
    end
    lat = 0;
    while (lat < 600) begin
      lat++;
      if (expq.size() <= 1) bus.cmd_valid = 1'b0;
      if (bus.done) break;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    if (!bus.done) begin
      total++; bad++;
      $display("FAIL done_timeout: got=0 want=1");
    end
    $display("cmd op=%0d src=%0d dst=%0d len=%0d data=%08h noise=%0d lat=%0d",
             op, src, dst, len, data, noise, lat);
  endtask

  initial begin
    int    lat;
    int    op, src, dst, len, r, delta;
    word_t d;
    int    want_a [8] = '{1, 2, 3, 4, 1, 2, 3, 4};
    int    want_b [8] = '{1, 2, 1, 2, 3, 4, 3, 4};

    for (int a = 0; a < DEPTH; a++) ref_mem[a] = init_word(a);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_FILL;
    bus.cmd_src   = '0;
    bus.cmd_dst   = '0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_mismatch", bus.mismatch_count, 0);
    chk("rst_wr_en", bus.mem_wr_en, 0);
    chk("rst_wr_addr", bus.mem_wr_addr, 0);
    chk("rst_wr_data", bus.mem_wr_data, 0);
    chk("rst_rd_addr", bus.mem_rd_addr, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // FILL dst=10 len=4
    do_cmd(0, 0, 10, 4, 32'hA5A5_0001, 1'b0, lat);
    chk("fill_latency", lat, 5);
    for (int a = 10; a < 14; a++) chk("fill_10_13", mem[a], 32'hA5A5_0001);
    chk("fill_below", mem[9], 32'hDEAD_0009);
    chk("fill_above", mem[14], 32'hDEAD_000E);

    // Overlapping COPY, descending then ascending
    for (int i = 0; i < 8; i++) do_cmd(0, 0, i, 1, 32'(i + 1), 1'b0, lat);
    do_cmd(1, 0, 4, 4, 32'h0, 1'b1, lat);
    for (int a = 0; a < 8; a++) chk("copy_desc", mem[a], 32'(want_a[a]));
    do_cmd(1, 4, 2, 4, 32'h0, 1'b1, lat);
    for (int a = 0; a < 8; a++) chk("copy_asc", mem[a], 32'(want_b[a]));

    // CHECK with one planted mismatch; result held while idle
    do_cmd(0, 0, 12, 1, 32'h0, 1'b0, lat);
    do_cmd(2, 10, 200, 4, 32'hA5A5_0001, 1'b1, lat);
    chk("check_latency", lat, 5);
    chk("check_mism_at_done", bus.mismatch_count, 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("check_mism_held", bus.mismatch_count, 1);

    // Wrap, zero length, reserved op
    do_cmd(0, 0, DEPTH - 1, 2, 32'h0BAD_F00D, 1'b0, lat);
    chk("wrap_top", mem[DEPTH - 1], 32'h0BAD_F00D);
    chk("wrap_zero", mem[0], 32'h0BAD_F00D);
    do_cmd(0, 0, 50, 0, 32'h1111_1111, 1'b0, lat);
    chk("len0_latency", lat, 1);
    chk("len0_untouched", mem[50], 32'hDEAD_0032);
    do_cmd(3, 0, 60, 5, 32'h2222_2222, 1'b0, lat);
    chk("rsvd_latency", lat, 1);
    chk("rsvd_untouched", mem[60], 32'hDEAD_003C);

    // Reset in the second element cycle of FILL len=8
    @(posedge clk); #1;
    chk_en = 1'b0;
    expq.delete();
    bus.cmd_op    = OP_FILL;
    bus.cmd_dst   = AW'(100);
    bus.cmd_len   = (AW + 1)'(8);
    bus.cmd_data  = 32'h5EED_0100;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    chk("rstmid_first_wr_en", bus.mem_wr_en, 1);
    chk("rstmid_first_addr", bus.mem_wr_addr, 100);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_wr_en", bus.mem_wr_en, 0);
    chk("rstmid_busy", bus.busy, 0);
    chk("rstmid_ready", bus.cmd_ready, 1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rstmid_no_done", bus.done, 0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    ref_mem[100] = 32'h5EED_0100;
    held_mism    = '0;
    chk("rstmid_elem0", mem[100], 32'h5EED_0100);
    chk("rstmid_elem1", mem[101], 32'hDEAD_0065);
    $display("reset mid-command FILL dst=100 len=8 aborted after element 0");
    chk_en = 1'b1;

    // Full-depth FILL
    do_cmd(0, 0, 37, DEPTH, 32'h1234_5678, 1'b0, lat);
    chk("full_latency", lat, DEPTH + 1);

    // Randomized commands
    for (int t = 0; t < 80; t++) begin
      r   = int'($urandom_range(0, 9));
      op  = (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
      len = int'($urandom_range(0, 24));
      src = int'($urandom_range(0, DEPTH - 1));
      dst = int'($urandom_range(0, DEPTH - 1));
      d   = $urandom;
      if (op == 1) begin
        src = int'($urandom_range(0, DEPTH - len));
        if ($urandom_range(0, 1) == 1) begin
          delta = int'($urandom_range(0, 8)) - 4;
          dst   = src + delta;
        end else begin
          dst = int'($urandom_range(0, DEPTH - len));
        end
        if (dst < 0) dst = 0;
        if (dst > DEPTH - len) dst = DEPTH - len;
      end
      if (op == 2 && $urandom_range(0, 1) == 1) d = ref_mem[src];
      do_cmd(op, src, dst, len, d, bit'($urandom_range(0, 1)), lat);
    end

    repeat (3) begin @(posedge clk); #1; end
    for (int a = 0; a < DEPTH; a++) chk("final_mem", mem[a], ref_mem[a]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
